wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter feeding the single shared write port of the integer and FPU register files. It merges the in-order pipeline result stream (M/W boundary) with out-of-order results from long-latency FPU units. Long-latency results are held in a small FIFO until a free writeback slot appears. It drives the `rd_w` / `result_w` / `reg_write_w` / `fpu_reg_write_w` bundle consumed by decode, and reports pending buffered destinations so decode can interlock.

## Interface
- `DEPTH`, 4, FIFO entries for long-latency FPU results; power of two, 2..16.
- `clk`  in  1  clock. Register files write on the opposite edge.
- `rstn`  in  1  synchronous active-low reset.
- `pipe_rd`  in  5  destination of in-order result.
- `pipe_result`  in  32  in-order result data.
- `pipe_reg_write`  in  1  in-order result targets integer file.
- `pipe_fpu_reg_write`  in  1  in-order result targets FPU file. Never both set together with `pipe_reg_write`.
- `fpu_valid`  in  1  long-latency FPU result offered.
- `fpu_ready`  out  1  FIFO can accept: `!full`.
- `fpu_rd`  in  5  destination of FPU result.
- `fpu_result`  in  32  FPU result data.
- `fpu_int_dst`  in  1  1 = integer file (feq, fcvt.w.s, …), 0 = FPU file.
- `rd_w`  out  5  registered write address.
- `result_w`  out  32  registered write data.
- `reg_write_w`  out  1  integer file write enable.
- `fpu_reg_write_w`  out  1  FPU file write enable.
- `chk_rs1`, `chk_rs2`, `chk_rs3`  in  5 each  decode source indices to check.
- `pend_x_rs1`, `pend_x_rs2`  out  1 each  a valid FIFO entry targets integer reg = `chk_rs*`. Never for index 0.
- `pend_f_rs1`, `pend_f_rs2`, `pend_f_rs3`  out  1 each  a valid FIFO entry targets FPU reg = `chk_rs*`.
- `fifo_count`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- **Output register selection.** Each rising edge, the output register loads from exactly one source, in strict priority:
  1. The pipe, if `pipe_reg_write | pipe_fpu_reg_write`.
  2. Otherwise the FIFO head, if the FIFO is non-empty; the head is popped.
  3. Otherwise the bypass (see Configuration).
  4. Otherwise idle: both enables are 0; `rd_w`/`result_w` hold their previous values.
- **Integer writes to x0** are suppressed: `reg_write_w` = 0. `rd_w` and `result_w` still load. FPU f0 is a real register and is written normally.
- **Push.** Occurs when `fpu_valid & fpu_ready` and the bypass is not taken. The entry stores {rd, result, int_dst}.
- **No push/pop overlap when full.** `fpu_ready` = 0 whenever count == DEPTH, even if a pop occurs that same cycle.
- **Simultaneous push and pop** on a non-empty, non-full FIFO leaves count unchanged.
- **Ordering.** FIFO entries retire in arrival order.
- **Starvation.** The pipe may starve the FIFO indefinitely. Backpressure reaches the FPU only through `fpu_ready`; no fairness is guaranteed.
- **Pointers.** Read/write pointers are log2(DEPTH) bits, wrap modulo DEPTH, and use an extra count bit to distinguish full from empty.
- **Pending flags** are combinational over valid FIFO entries only. The output register is excluded because the register file commits it before the next decode read.

## Timing
- Pipe input at edge t → write bundle valid after t, committed by the register file on the following falling edge. Latency 1 cycle.
- FPU result accepted at t and enqueued → earliest output after t+1 (pop at t+1). Minimum latency 2.
- With bypass taken → output after t. Latency 1.
- Reset (synchronous, `rstn`=0 at an edge):
  - count = 0, pointers = 0.
  - `rd_w` = 0, `result_w` = 0, `reg_write_w` = 0, `fpu_reg_write_w` = 0.
  - `fpu_ready` = 1 after reset, since it depends on count.
  - All pend flags 0.
- Reset mid-operation discards buffered entries; no write for them is ever issued.
- `fpu_ready` and the pend flags depend only on state and `chk_rs*`. There is no combinational path from `fpu_valid`.

## Configuration
- `WB_FPU_BYPASS_EN` defined:
  - When the pipe is idle and the FIFO is empty, an accepted FPU result loads the output register directly at the same edge. It is not pushed. Latency 1.
- Undefined:
  - Every accepted FPU result is pushed. Minimum latency 2.
  - The priority order drops rule 3.

## Test plan
- **Reset.** Hold `rstn`=0 two cycles with `fpu_valid`=1 → all outputs 0, `fpu_ready`=1, `fifo_count`=0. After release, there is no write from the inputs presented during reset.
- **Pipe priority.** `pipe_reg_write`=1, rd=5, 0xDEADBEEF each cycle for 6 cycles, while FPU offers rd=3/0x3F800000/int_dst=0 every cycle (DEPTH=4):
  - The pipe writes appear each cycle.
  - `fpu_ready` drops after 4 accepts; `pend_f_rs1`=1 for `chk_rs1`=3.
  - Once the pipe goes idle, the 4 FPU writes drain in order, one per cycle, with `fpu_reg_write_w`=1.
- **x0 suppression.** Pipe int write rd=0 → `reg_write_w`=0. FPU write rd=0 with int_dst=0 → `fpu_reg_write_w`=1 with rd_w=0.
- **Bypass latency.** Idle pipe, empty FIFO, one FPU result at t:
  - With `WB_FPU_BYPASS_EN`: write after t and `fifo_count` stays 0.
  - Without: `fifo_count`=1 after t, write after t+1.
- **Full-boundary and wrap.** Fill to 4, then pop one per idle cycle while offering new results continuously:
  - No accept in the cycle where count==4.
  - After 10 total results, the pointers have wrapped and the retire order matches the issue order exactly.
- **Integer destination from FPU.** FPU result int_dst=1, rd=7, 1 → `reg_write_w`=1, `fpu_reg_write_w`=0. While buffered, `pend_x_rs2`=1 for `chk_rs2`=7.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the in-order pipeline result stream with out-of-order
// long-latency FPU results onto the single shared register-file write port.
// FPU results wait in a DEPTH-entry FIFO until the pipe leaves a slot free.
// Pending flags let decode interlock on destinations that are still buffered.
//
// Optional feature: define WB_FPU_BYPASS_EN to let an FPU result skip the
// FIFO when the pipe is idle and the FIFO is empty. It then has 1-cycle
// latency. Without it, every accepted FPU result is pushed into the FIFO.

module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,

  // In-order pipeline result (M/W boundary)
  input  logic [4:0]                 pipe_rd,
  input  logic [31:0]                pipe_result,
  input  logic                       pipe_reg_write,
  input  logic                       pipe_fpu_reg_write,

  // Long-latency FPU result
  input  logic                       fpu_valid,
  output logic                       fpu_ready,
  input  logic [4:0]                 fpu_rd,
  input  logic [31:0]                fpu_result,
  input  logic                       fpu_int_dst,

  // Registered write bundle
  output logic [4:0]                 rd_w,
  output logic [31:0]                result_w,
  output logic                       reg_write_w,
  output logic                       fpu_reg_write_w,

  // Decode interlock queries
  input  logic [4:0]                 chk_rs1,
  input  logic [4:0]                 chk_rs2,
  input  logic [4:0]                 chk_rs3,
  output logic                       pend_x_rs1,
  output logic                       pend_x_rs2,
  output logic                       pend_f_rs1,
  output logic                       pend_f_rs2,
  output logic                       pend_f_rs3,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // One buffered FPU result
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        int_dst;
  } entry_t;

  // FIFO state
  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Output register
  logic [4:0]      r_rd_w;
  logic [31:0]     r_result_w;
  logic            r_reg_write_w;
  logic            r_fpu_reg_write_w;

  // Source selection
  logic            w_pipe_sel;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_bypass;
  entry_t          w_head;
  entry_t          w_in;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pipe_sel = pipe_reg_write | pipe_fpu_reg_write;

  // The pipe always wins; the FIFO head is only popped in a free slot.
  assign w_pop      = !w_pipe_sel && !w_empty;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_in       = '{rd: fpu_rd, data: fpu_result, int_dst: fpu_int_dst};

  // Readiness depends on state only. A pop in the same cycle does not
  // reopen a full FIFO.
  assign fpu_ready  = !w_full;

`ifdef WB_FPU_BYPASS_EN
  // A free slot with nothing buffered lets the FPU result go straight through.
  assign w_bypass   = !w_pipe_sel && w_empty && fpu_valid;
`else
  assign w_bypass   = 1'b0;
`endif

  assign w_push     = fpu_valid && fpu_ready && !w_bypass;

  // FIFO storage write
  // NOTE: data storage is deliberately left out of reset. Only pointers and
  // count are reset, and entries are never read unless count marks them valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: pipe > FIFO head > bypass > idle. Integer x0 writes
  // are suppressed, but address and data still load.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_w            <= '0;
      r_result_w        <= '0;
      r_reg_write_w     <= 1'b0;
      r_fpu_reg_write_w <= 1'b0;
    end else if (w_pipe_sel) begin
      r_rd_w            <= pipe_rd;
      r_result_w        <= pipe_result;
      r_reg_write_w     <= pipe_reg_write && (pipe_rd != 5'd0);
      r_fpu_reg_write_w <= pipe_fpu_reg_write;
    end else if (w_pop) begin
      r_rd_w            <= w_head.rd;
      r_result_w        <= w_head.data;
      r_reg_write_w     <= w_head.int_dst && (w_head.rd != 5'd0);
      r_fpu_reg_write_w <= !w_head.int_dst;
    end else if (w_bypass) begin
      r_rd_w            <= fpu_rd;
      r_result_w        <= fpu_result;
      r_reg_write_w     <= fpu_int_dst && (fpu_rd != 5'd0);
      r_fpu_reg_write_w <= !fpu_int_dst;
    end else begin
      r_reg_write_w     <= 1'b0;
      r_fpu_reg_write_w <= 1'b0;
    end
  end

  // Pending-destination scan over valid FIFO entries only
  always_comb begin
    logic [AW-1:0] v_off;
    logic          v_valid;
    // NOTE: every variable gets a default before any conditional update,
    // so no path leaves one unassigned and no latch is inferred.
    v_off      = '0;
    v_valid    = 1'b0;
    pend_x_rs1 = 1'b0;
    pend_x_rs2 = 1'b0;
    pend_f_rs1 = 1'b0;
    pend_f_rs2 = 1'b0;
    pend_f_rs3 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      // An entry is live if it lies within count slots of the read pointer.
      v_off   = AW'(i) - r_rd_ptr;
      v_valid = ({1'b0, v_off} < r_count);
      if (v_valid) begin
        if (r_mem[i].int_dst) begin
          if (chk_rs1 != 5'd0 && r_mem[i].rd == chk_rs1) pend_x_rs1 = 1'b1;
          if (chk_rs2 != 5'd0 && r_mem[i].rd == chk_rs2) pend_x_rs2 = 1'b1;
        end else begin
          if (r_mem[i].rd == chk_rs1) pend_f_rs1 = 1'b1;
          if (r_mem[i].rd == chk_rs2) pend_f_rs2 = 1'b1;
          if (r_mem[i].rd == chk_rs3) pend_f_rs3 = 1'b1;
        end
      end
    end
  end

  assign rd_w            = r_rd_w;
  assign result_w        = r_result_w;
  assign reg_write_w     = r_reg_write_w;
  assign fpu_reg_write_w = r_fpu_reg_write_w;
  assign fifo_count      = r_count;

endmodule
